router_port_arbiter: RTL and testbench
======================================

# router_port_arbiter

Round-robin arbiter that shares one router output port between `NUM_REQ` node-side input FIFOs. Each FIFO offers its head packet with the `pkt_avail`/`data_taken` handshake. The arbiter accepts only packets whose `destID` matches this port, moves the winner into a one-entry output register, and presents it downstream with the same handshake. One instance sits in front of each router output buffer.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesting input FIFOs (2..8).
- `PORT_ID`, 4'd0, `destID` served by this port; packets with any other `destID` are never granted.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst_b`  in  1  synchronous, active-high reset (asserted = 1). The name matches the rest of the design.
- `req_avail`  in  `NUM_REQ`  bit i = FIFO i has a valid head packet.
- `req_pkt`  in  `pkt_t [NUM_REQ]`  head packet of each FIFO.
- `req_taken`  out  `NUM_REQ`  one-hot pop strobe to FIFO i (combinational).
- `out_avail`  out  1  `out_pkt` holds a valid packet.
- `out_pkt`  out  `pkt_t`  packet offered downstream.
- `out_taken`  in  1  downstream consumed `out_pkt` this cycle.
- `grant_id`  out  `$clog2(NUM_REQ)`  index of the requester whose packet is in `out_pkt`.
- `pkt_count`  out  16  packets delivered (count of `out_taken` while `out_avail`); wraps at 2^16.

## Operation
- `eligible[i] = req_avail[i] && req_pkt[i].destID == PORT_ID`.
- Rotating pointer `ptr`. Winner = first eligible index scanning `ptr, ptr+1, …` mod `NUM_REQ`.
- FSM, two states:
  - IDLE: `out_avail`=0. If any eligible: `req_taken[winner]`=1, capture `req_pkt[winner]` into `out_pkt`, `grant_id`<=winner, `ptr`<=(winner+1) mod `NUM_REQ`, go to SEND. If none eligible, stay.
  - SEND: `out_avail`=1, `out_pkt` held stable. If `out_taken`=0, stay with no grant. If `out_taken`=1: increment `pkt_count`. If any eligible, grant immediately as in IDLE (back-to-back) and stay in SEND. Otherwise go to IDLE.
- `req_taken` is at most one-hot. It is asserted only in a cycle where the capture edge occurs, and never while `rst_b`=1.
- Ineligible requesters (wrong `destID`) are skipped and do not move `ptr`.
- `req_pkt` source/data fields are passed through unmodified.

## Timing
- Reset values: state IDLE, `ptr`=0, `out_avail`=0, `out_pkt`=0, `grant_id`=0, `pkt_count`=0, `req_taken`=0.
- Latency: an eligible request in IDLE at cycle n gives `out_avail`=1 with that packet at cycle n+1.
- Throughput: 1 packet/cycle while `out_taken` is held high and an eligible request exists every cycle.
- `out_taken` while `out_avail`=0: ignored, no count.
- Simultaneous `out_taken` and a new eligible request: old packet retires and new packet loads on the same edge. There is no bubble and `pkt_count` increments once.
- Requester drops `req_avail` before being granted: no effect, no pop.
- Reset mid-SEND: the held packet is discarded and not counted. `req_taken` is 0 during the reset cycle, so no FIFO pops.
- `pkt_count` wraps from 16'hFFFF to 0.
- Fairness: an eligible requester held continuously is granted within `NUM_REQ` grants.

## Structure
- Package `router_pkg`: the `pkt_t` typedef (`sourceID`[3:0], `destID`[3:0], `data`[23:0], packed) and constant `NUM_NODES`=4. Shared with FIFO, node, and router.
- Sub-module `rr_picker`: combinational rotating-priority encoder. Inputs `eligible` and `ptr`; outputs `any` and `winner`. Instantiated once.
- The arbiter's FSM, pointer, output register, and counter live in `router_port_arbiter`.

## Test plan
- Reset, then idle with no requests: all outputs stay at reset values; `req_taken`=0 every cycle.
- FIFO 2 offers {src 2, dest 0, data 45}, `out_taken`=0: `req_taken`=4'b0100 for one cycle. Next cycle `out_avail`=1, `out_pkt.data`=45, `grant_id`=2. The packet is held until `out_taken`, then `pkt_count`=1.
- All four FIFOs eligible continuously, `out_taken`=1: grants go 0,1,2,3,0,…, one per cycle; after 8 cycles `pkt_count`=8.
- FIFO 1 has `destID`=3, FIFO 3 has `destID`=0, `PORT_ID`=0: only FIFO 3 is granted; `req_taken[1]` is never asserted.
- Reset asserted while in SEND with `out_pkt.data`=22: next cycle `out_avail`=0, `pkt_count` unchanged, no `req_taken` during reset.
- Preload `pkt_count`=16'hFFFE via 65534 deliveries, then 2 more: reads 16'hFFFF, then 0.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg
// Shared types for the router: the packet format carried between node FIFOs,
// the router and its output buffers, plus the port arbiter FSM state type.
// No ports (package).
package router_pkg;

  localparam int NUM_NODES = 4;

  typedef struct packed {
    logic [3:0]  sourceID;
    logic [3:0]  destID;
    logic [23:0] data;
  } pkt_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_t;

endpackage

// File: rtl/router_port_arbiter_if.sv
// router_port_arbiter_if
// Bundles the requester-side and downstream-side handshakes of one router
// output port arbiter.
//   req_avail  : per-FIFO head-packet valid
//   req_pkt    : per-FIFO head packet
//   req_taken  : per-FIFO pop strobe (one-hot)
//   out_avail  : output register holds a packet
//   out_pkt    : packet offered downstream
//   out_taken  : downstream consumed out_pkt
//   grant_id   : requester index of the packet in out_pkt
//   pkt_count  : delivered-packet counter
// modport master: arbiter side; modport slave: FIFOs + downstream side.
interface router_port_arbiter_if
  import router_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_avail;
  pkt_t [NUM_REQ-1:0] req_pkt;
  logic [NUM_REQ-1:0] req_taken;
  logic               out_avail;
  pkt_t               out_pkt;
  logic               out_taken;
  logic [GW-1:0]      grant_id;
  logic [15:0]        pkt_count;

  modport master (
    input  req_avail, req_pkt, out_taken,
    output req_taken, out_avail, out_pkt, grant_id, pkt_count
  );

  modport slave (
    output req_avail, req_pkt, out_taken,
    input  req_taken, out_avail, out_pkt, grant_id, pkt_count
  );

endinterface

// File: rtl/router_port_arbiter_rr_picker.sv
// rr_picker
// Combinational rotating-priority encoder: returns the first set bit of
// `eligible` scanning upward from `ptr` and wrapping modulo NUM_REQ.
//   eligible : in  NUM_REQ  candidate mask
//   ptr      : in  PW       highest-priority index this cycle
//   any      : out 1        at least one candidate
//   winner   : out PW       selected index (0 when any=0)
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PW-1:0]      ptr,
  output logic               any,
  output logic [PW-1:0]      winner
);

  logic [PW-1:0] idx_s;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx_s  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_s = PW'((int'(ptr) + k) % NUM_REQ);
      if (eligible[idx_s]) begin
        any    = 1'b1;
        winner = idx_s;
      end else begin
        any    = any;
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/router_port_arbiter.sv
// router_port_arbiter
// Round-robin arbiter sharing one router output port between NUM_REQ input
// FIFOs. Only packets addressed to PORT_ID compete. The winner is popped and
// loaded into a one-entry output register that is offered downstream.
//   clk   : clock, all state on posedge
//   rst_b : synchronous reset, active high
//   bus   : router_port_arbiter_if.master (request and output handshakes)
module router_port_arbiter
  import router_pkg::*;
#(
  parameter int         NUM_REQ = 4,
  parameter logic [3:0] PORT_ID = 4'd0
) (
  input logic                  clk,
  input logic                  rst_b,
  router_port_arbiter_if.master bus
);

  localparam int            PW       = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  arb_state_t         state_r;
  arb_state_t         state_next_s;
  logic [PW-1:0]      ptr_r;
  logic [PW-1:0]      ptr_next_s;
  logic [PW-1:0]      winner_s;
  logic [NUM_REQ-1:0] eligible_s;
  logic [NUM_REQ-1:0] req_taken_s;
  logic               any_s;
  logic               grant_s;
  logic               retire_s;
  pkt_t               out_pkt_r;
  logic [PW-1:0]      grant_id_r;
  logic [15:0]        pkt_count_r;

  // Requester eligibility: valid head packet addressed to this port.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = bus.req_avail[i] && (bus.req_pkt[i].destID == PORT_ID);
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .eligible (eligible_s),
    .ptr      (ptr_r),
    .any      (any_s),
    .winner   (winner_s)
  );

  // Priority moves to the slot after the winner; explicit wrap keeps
  // non-power-of-two NUM_REQ correct.
  assign ptr_next_s = (winner_s == LAST_IDX) ? '0 : winner_s + PW'(1);

  // Next-state and grant/retire decode.
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (any_s) begin
          grant_s      = 1'b1;
          state_next_s = ARB_SEND;
        end else begin
          state_next_s = ARB_IDLE;
        end
      end
      ARB_SEND: begin
        if (bus.out_taken) begin
          retire_s = 1'b1;
          // Retire and reload on the same edge: no bubble between packets.
          if (any_s) begin
            grant_s      = 1'b1;
            state_next_s = ARB_SEND;
          end else begin
            state_next_s = ARB_IDLE;
          end
        end else begin
          state_next_s = ARB_SEND;
        end
      end
      default: begin
        state_next_s = ARB_IDLE;
      end
    endcase
  end

  // Pop strobe; masked during reset so no FIFO loses a packet that the
  // output register will not keep.
  always_comb begin
    req_taken_s = '0;
    if (grant_s && !rst_b) begin
      req_taken_s[winner_s] = 1'b1;
    end else begin
      req_taken_s = '0;
    end
  end

  // State, pointer, output register and delivery counter.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_r     <= ARB_IDLE;
      ptr_r       <= '0;
      out_pkt_r   <= '0;
      grant_id_r  <= '0;
      pkt_count_r <= 16'd0;
    end else begin
      state_r <= state_next_s;
      if (grant_s) begin
        out_pkt_r  <= bus.req_pkt[winner_s];
        grant_id_r <= winner_s;
        ptr_r      <= ptr_next_s;
      end
      if (retire_s) begin
        pkt_count_r <= pkt_count_r + 16'd1;
      end
    end
  end

  assign bus.req_taken = req_taken_s;
  assign bus.out_avail = (state_r == ARB_SEND);
  assign bus.out_pkt   = out_pkt_r;
  assign bus.grant_id  = grant_id_r;
  assign bus.pkt_count = pkt_count_r;

endmodule

// File: tb/tb_router_port_arbiter.sv
// tb_router_port_arbiter
// Self-checking bench for router_port_arbiter (NUM_REQ=4, PORT_ID=0).
// Inputs change 1 time unit after posedge; req_taken is checked 1 unit
// later, registered outputs 1 unit after the next posedge, and deliveries
// are popped from the expected-packet queue at negedge.
module tb_router_port_arbiter;
  import router_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] gid;
    pkt_t       pkt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  router_port_arbiter_if #(.NUM_REQ(N)) bus ();

  router_port_arbiter #(
    .NUM_REQ (N),
    .PORT_ID (4'd0)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  function automatic pkt_t mk(input int src, input int dst, input int data);
    pkt_t p;
    p.sourceID = 4'(src);
    p.destID   = 4'(dst);
    p.data     = 24'(data);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int gid, input pkt_t p);
    exp_t e;
    e.gid = 2'(gid);
    e.pkt = p;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every downstream delivery must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_avail === 1'b1 && bus.out_taken === 1'b1 && rst_b === 1'b0) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: delivered gid=%0d pkt=%h, nothing expected", bus.grant_id, bus.out_pkt);
      end else begin
        e = sb_q.pop_front();
        if (bus.grant_id !== e.gid || bus.out_pkt !== e.pkt) begin
          n_fail++;
          $display("FAIL sb_delivery: got gid=%0d pkt=%h, expected gid=%0d pkt=%h",
                   bus.grant_id, bus.out_pkt, e.gid, e.pkt);
        end
      end
    end
  end

  task automatic test_reset();
    rst_b = 1'b1;
    bus.req_avail = '0;
    bus.req_pkt   = '0;
    bus.out_taken = 1'b0;
    tick();
    tick();
    rst_b = 1'b0;
    n_checks++;
    if (bus.out_avail !== 1'b0 || bus.out_pkt !== '0 || bus.grant_id !== 2'd0 || bus.pkt_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: avail=%b pkt=%h gid=%0d cnt=%0d, expected all 0",
               bus.out_avail, bus.out_pkt, bus.grant_id, bus.pkt_count);
    end
    // Idle with out_taken high: must be ignored.
    for (int c = 0; c < 4; c++) begin
      bus.out_taken = 1'b1;
      #1;
      n_checks++;
      if (bus.req_taken !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_req_taken: got %b expected 0000", bus.req_taken);
      end
      tick();
      n_checks++;
      if (bus.out_avail !== 1'b0 || bus.pkt_count !== 16'd0) begin
        n_fail++;
        $display("FAIL idle_outputs: avail=%b cnt=%0d expected 0/0", bus.out_avail, bus.pkt_count);
      end
    end
    bus.out_taken = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    bus.req_pkt[0] = mk(0, 0, 22);
    bus.req_avail  = 4'b0001;
    bus.out_taken  = 1'b0;
    #1;
    n_checks++;
    if (bus.req_taken !== 4'b0001) begin
      n_fail++;
      $display("FAIL rms_grant: req_taken=%b expected 0001", bus.req_taken);
    end
    tick();
    bus.req_pkt[0] = mk(0, 0, 23);
    n_checks++;
    if (bus.out_avail !== 1'b1 || bus.out_pkt.data !== 24'd22) begin
      n_fail++;
      $display("FAIL rms_loaded: avail=%b data=%0d expected 1/22", bus.out_avail, bus.out_pkt.data);
    end
    // Reset with a taker and an eligible request: nothing may pop.
    rst_b = 1'b1;
    bus.out_taken = 1'b1;
    #1;
    n_checks++;
    if (bus.req_taken !== 4'b0000) begin
      n_fail++;
      $display("FAIL rms_no_pop: req_taken=%b expected 0000 during reset", bus.req_taken);
    end
    tick();
    rst_b = 1'b0;
    bus.req_avail = '0;
    bus.out_taken = 1'b0;
    n_checks++;
    if (bus.out_avail !== 1'b0 || bus.pkt_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rms_discard: avail=%b cnt=%0d expected 0/0", bus.out_avail, bus.pkt_count);
    end
  endtask

  task automatic test_single();
    pkt_t p45;
    p45 = mk(2, 0, 45);
    bus.req_pkt[2] = p45;
    bus.req_avail  = 4'b0100;
    bus.out_taken  = 1'b0;
    #1;
    n_checks++;
    if (bus.req_taken !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_pop: req_taken=%b expected 0100", bus.req_taken);
    end
    push_exp(2, p45);
    tick();
    bus.req_avail = 4'b0000;
    n_checks++;
    if (bus.out_avail !== 1'b1 || bus.out_pkt.data !== 24'd45 || bus.grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL single_load: avail=%b data=%0d gid=%0d expected 1/45/2",
               bus.out_avail, bus.out_pkt.data, bus.grant_id);
    end
    // Hold: FIFO 0 requests then withdraws before any grant.
    for (int h = 0; h < 3; h++) begin
      bus.req_pkt[0] = mk(0, 0, 9);
      bus.req_avail  = (h < 2) ? 4'b0001 : 4'b0000;
      #1;
      n_checks++;
      if (bus.req_taken !== 4'b0000) begin
        n_fail++;
        $display("FAIL hold_no_pop: req_taken=%b expected 0000", bus.req_taken);
      end
      tick();
      n_checks++;
      if (bus.out_avail !== 1'b1 || bus.out_pkt !== p45 || bus.pkt_count !== 16'd0) begin
        n_fail++;
        $display("FAIL hold_stable: avail=%b pkt=%h cnt=%0d expected 1/%h/0",
                 bus.out_avail, bus.out_pkt, bus.pkt_count, p45);
      end
    end
    bus.out_taken = 1'b1;
    tick();
    bus.out_taken = 1'b0;
    n_checks++;
    if (bus.out_avail !== 1'b0 || bus.pkt_count !== 16'd1 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_retire: avail=%b cnt=%0d pending=%0d expected 0/1/0",
               bus.out_avail, bus.pkt_count, sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_rt;
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) bus.req_pkt[i] = mk(i, 0, 200 + k * 4 + i);
      bus.req_avail = 4'b1111;
      bus.out_taken = (k > 0);
      exp_rt = '0;
      exp_rt[k % N] = 1'b1;
      #1;
      n_checks++;
      if (bus.req_taken !== exp_rt) begin
        n_fail++;
        $display("FAIL b2b_order: cycle %0d req_taken=%b expected %b", k, bus.req_taken, exp_rt);
      end
      push_exp(k % N, bus.req_pkt[k % N]);
      tick();
      n_checks++;
      if (bus.out_avail !== 1'b1 || bus.pkt_count !== 16'(k)) begin
        n_fail++;
        $display("FAIL b2b_rate: cycle %0d avail=%b cnt=%0d expected 1/%0d", k, bus.out_avail, bus.pkt_count, k);
      end
    end
    bus.req_avail = '0;
    bus.out_taken = 1'b1;
    tick();
    bus.out_taken = 1'b0;
    n_checks++;
    if (bus.pkt_count !== 16'd8 || bus.out_avail !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_total: cnt=%0d avail=%b pending=%0d expected 8/0/0",
               bus.pkt_count, bus.out_avail, sb_q.size());
    end
  endtask

  task automatic test_dest_filter();
    bus.req_pkt[1] = mk(1, 3, 77);
    for (int c = 0; c < 6; c++) begin
      bus.req_pkt[3] = mk(3, 0, 88 + c);
      bus.req_avail  = (c < 4) ? 4'b1010 : 4'b0010;
      bus.out_taken  = (c > 0);
      #1;
      n_checks++;
      if (bus.req_taken !== ((c < 4) ? 4'b1000 : 4'b0000)) begin
        n_fail++;
        $display("FAIL dest_filter: cycle %0d req_taken=%b expected %b",
                 c, bus.req_taken, (c < 4) ? 4'b1000 : 4'b0000);
      end
      if (c < 4) push_exp(3, bus.req_pkt[3]);
      tick();
      n_checks++;
      if (bus.out_avail !== (c < 4)) begin
        n_fail++;
        $display("FAIL dest_avail: cycle %0d avail=%b expected %b", c, bus.out_avail, (c < 4));
      end
    end
    bus.req_avail = '0;
    bus.out_taken = 1'b0;
    n_checks++;
    if (bus.pkt_count !== 16'd12 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL dest_count: cnt=%0d pending=%0d expected 12/0", bus.pkt_count, sb_q.size());
    end
  endtask

  task automatic test_wrap();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    bus.req_pkt[0] = mk(0, 0, 0);
    bus.req_avail  = 4'b0001;
    bus.out_taken  = 1'b0;
    push_exp(0, bus.req_pkt[0]);
    tick();
    for (int j = 1; j < 65536; j++) begin
      bus.req_pkt[0] = mk(0, 0, j);
      bus.out_taken  = 1'b1;
      #1;
      n_checks++;
      if (bus.req_taken !== 4'b0001) begin
        n_fail++;
        $display("FAIL wrap_stream: cycle %0d req_taken=%b expected 0001", j, bus.req_taken);
      end
      push_exp(0, bus.req_pkt[0]);
      tick();
      if (j == 65534) begin
        n_checks++;
        if (bus.pkt_count !== 16'hFFFE) begin
          n_fail++;
          $display("FAIL wrap_fffe: cnt=%h expected fffe", bus.pkt_count);
        end
      end
      if (j == 65535) begin
        n_checks++;
        if (bus.pkt_count !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL wrap_ffff: cnt=%h expected ffff", bus.pkt_count);
        end
      end
    end
    bus.req_avail = '0;
    tick();
    bus.out_taken = 1'b0;
    n_checks++;
    if (bus.pkt_count !== 16'h0000 || bus.out_avail !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_zero: cnt=%h avail=%b pending=%0d expected 0000/0/0",
               bus.pkt_count, bus.out_avail, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_send();
    test_single();
    test_back_to_back();
    test_dest_filter();
    test_wrap();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
